// File: rtl/cmos_wr_packer.sv
// ---------------------------------------------------------------------------
// cmos_wr_packer
//   Camera-side write packer. Sits behind the OV7725 driver in the pixel-clock
//   domain: discards SKIP_FRAMES start-up frames, packs four RGB565 pixels
//   into one 64-bit word per write and pushes the words into the frame-buffer
//   write FIFO. It flags frame boundaries and raises sticky error flags for
//   words lost to a full FIFO and for frames of the wrong size.
//
//   Optional build macro: CMOS_WR_STAT_EN. When defined, this adds the
//   stat_lines/stat_pixels outputs, which hold the geometry of the last
//   captured frame.
//
// Ports
//   clk               camera pixel clock
//   rst_n             asynchronous active-low reset
//   cmos_frame_vsync  frame sync (rising edge = frame boundary)
//   cmos_frame_href   line valid (falling edge = line end)
//   cmos_frame_valid  pixel strobe for cmos_frame_data
//   cmos_frame_data   RGB565 pixel
//   fifo_full         downstream FIFO cannot take a write this cycle
//   wr_en / wr_data   registered write strobe and packed word (pixel 0 in [15:0])
//   frame_start       pulse on the vs_rise that opens a captured frame
//   frame_done        pulse on the vs_rise that closes a captured/dropped frame
//   ovf_err           sticky: a word was lost to fifo_full
//   size_err          sticky: a captured frame had a wrong line/pixel count
//   stat_lines        (CMOS_WR_STAT_EN) line count of the last closed frame
//   stat_pixels       (CMOS_WR_STAT_EN) pixel count of that frame's last line
// ---------------------------------------------------------------------------

// One 16-bit holding lane of the packing register.
module cmos_wr_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
endmodule

module cmos_wr_packer #(
  parameter int H_PIXEL     = 640,
  parameter int V_PIXEL     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_frame_vsync,
  input  logic        cmos_frame_href,
  input  logic        cmos_frame_valid,
  input  logic [15:0] cmos_frame_data,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [63:0] wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        ovf_err,
  output logic        size_err
`ifdef CMOS_WR_STAT_EN
  ,
  output logic [11:0] stat_lines,
  output logic [11:0] stat_pixels
`endif
);

  localparam int LANES = 4;
  localparam int PW    = $clog2(H_PIXEL + 1);
  localparam int LW    = $clog2(V_PIXEL + 1);

  localparam logic [PW-1:0] PIX_MAX  = '1;
  localparam logic [LW-1:0] LINE_MAX = '1;
  localparam logic [PW-1:0] PIX_EXP  = PW'(H_PIXEL);
  localparam logic [LW-1:0] LINE_EXP = LW'(V_PIXEL);

  localparam logic [1:0] S_SKIP   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DROP   = 2'd3;

  logic [1:0]    state;
  logic [7:0]    skip_cnt;
  logic [PW-1:0] pix_cnt, pix_nxt, last_pix;
  logic [LW-1:0] line_cnt, line_nxt;
  logic          vsync_d, href_d;
  logic          vs_rise, href_fall;
  logic          pix_take, word_done, line_end, line_bad, frame_bad;
  logic [1:0]    lane;
  logic [LANES-2:0][15:0] pack;
  logic [63:0]   word;

  assign vs_rise   = cmos_frame_vsync & ~vsync_d;
  assign href_fall = ~cmos_frame_href & href_d;

  // A pixel arriving with a frame boundary belongs to no frame: drop it.
  assign pix_take  = (state == S_ACTIVE) && cmos_frame_valid && !vs_rise;
  assign lane      = pix_cnt[1:0];
  assign word_done = pix_take && (lane == 2'd3);

  // Saturating counters so an oversized line/frame can never wrap back
  // onto the expected value and hide the size error.
  assign pix_nxt   = (pix_take && pix_cnt != PIX_MAX) ? pix_cnt + 1'b1 : pix_cnt;
  assign line_end  = (state == S_ACTIVE) && href_fall;
  assign line_nxt  = (line_end && line_cnt != LINE_MAX) ? line_cnt + 1'b1 : line_cnt;
  assign line_bad  = line_end && (pix_nxt != PIX_EXP);
  // Uses line_nxt so a line ending on the same cycle as vs_rise is counted.
  assign frame_bad = (line_nxt != LINE_EXP);

  assign frame_start = vs_rise && (state == S_ARM || state == S_ACTIVE);
  assign frame_done  = vs_rise && (state == S_ACTIVE || state == S_DROP);

  // Lanes 0..2 are held; lane 3 is taken straight from the input bus.
  for (genvar i = 0; i < LANES - 1; i++) begin : g_lane
    cmos_wr_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (pix_take && lane == 2'(i)),
      .d     (cmos_frame_data),
      .q     (pack[i])
    );
  end

  assign word = {cmos_frame_data, pack};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_SKIP;
      skip_cnt <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      last_pix <= '0;
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      ovf_err  <= 1'b0;
      size_err <= 1'b0;
    end else begin
      vsync_d <= cmos_frame_vsync;
      href_d  <= cmos_frame_href;
      wr_en   <= 1'b0;
      case (state)
        S_SKIP: begin
          if (vs_rise) begin
            skip_cnt <= skip_cnt + 1'b1;
            // >= also covers SKIP_FRAMES = 0 (arm on the first boundary).
            if ({1'b0, skip_cnt} + 9'd1 >= 9'(SKIP_FRAMES))
              state <= S_ARM;
          end
        end
        S_ARM: begin
          if (vs_rise) begin
            state    <= S_ACTIVE;
            pix_cnt  <= '0;
            line_cnt <= '0;
            last_pix <= '0;
          end
        end
        S_ACTIVE: begin
          if (vs_rise) begin
            // Close this frame and open the next one back-to-back.
            if (line_bad || frame_bad) size_err <= 1'b1;
            pix_cnt  <= '0;
            line_cnt <= '0;
            last_pix <= '0;
          end else begin
            pix_cnt  <= pix_nxt;
            line_cnt <= line_nxt;
            if (word_done) begin
              if (fifo_full) begin
                // Losing one word would tear the frame; drop the rest of it.
                ovf_err <= 1'b1;
                state   <= S_DROP;
              end else begin
                wr_en   <= 1'b1;
                wr_data <= word;
              end
            end
            if (line_end) begin
              // Any partial word left in the lanes is simply abandoned.
              if (line_bad) size_err <= 1'b1;
              last_pix <= pix_nxt;
              pix_cnt  <= '0;
            end
          end
        end
        S_DROP: begin
          if (vs_rise) state <= S_ARM;
        end
        default: state <= S_SKIP;
      endcase
    end
  end

`ifdef CMOS_WR_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lines  <= '0;
      stat_pixels <= '0;
    end else if (vs_rise && state == S_ACTIVE) begin
      stat_lines  <= 12'(line_nxt);
      // If the last line ends on this very cycle its count is still live.
      stat_pixels <= line_end ? 12'(pix_cnt) : 12'(last_pix);
    end
  end
`endif

endmodule

// File: doc/cmos_wr_packer.md
Name: cmos_wr_packer

Overview:
- Sits directly downstream of the OV7725 camera driver, in the camera pixel-clock domain.
- Consumes the per-pixel frame stream (vsync, href, valid, 16-bit RGB565 data).
- Skips start-up frames, packs four pixels into one 64-bit word and pushes the words into the write-side FIFO that feeds the DDR/HDMI frame buffer.
- Generates frame-boundary pulses and sticky error flags for overflow and wrong frame size.

Parameters:
- H_PIXEL, 640: active pixels per line. Must be a multiple of 4.
- V_PIXEL, 480: active lines per frame.
- SKIP_FRAMES, 10: number of complete frames discarded after reset before capture begins (0 to 255).

Ports:
- clk  input  1  camera pixel clock (cmos_frame_* domain).
- rst_n  input  1  asynchronous active-low reset.
- cmos_frame_vsync  input  1  frame sync; its rising edge marks a frame boundary.
- cmos_frame_href  input  1  line valid; its falling edge marks line end.
- cmos_frame_valid  input  1  one pixel present on cmos_frame_data.
- cmos_frame_data  input  16  RGB565 pixel.
- fifo_full  input  1  downstream FIFO cannot accept a write this cycle.
- wr_en  output  1  write strobe for wr_data.
- wr_data  output  64  four packed pixels.
- frame_start  output  1  one-cycle pulse; the first word of a new captured frame follows.
- frame_done  output  1  one-cycle pulse; a captured frame ended.
- ovf_err  output  1  sticky: a word was lost to fifo_full.
- size_err  output  1  sticky: a captured frame had the wrong line or pixel count.

Behaviour:
- Reset values: every output is 0; the state machine is in SKIP with the skip count at 0.
- Edge detection:
  - vsync and href are registered once.
  - vs_rise = vsync & ~vsync_d.
  - href_fall = ~href & href_d.
- State SKIP:
  - Each vs_rise increments the skip counter.
  - When the count reaches SKIP_FRAMES, the state moves to ARM.
  - With SKIP_FRAMES = 0, the state moves to ARM on the first vs_rise.
  - Pixels are ignored in this state.
- State ARM:
  - On the next vs_rise, move to ACTIVE.
  - Pulse frame_start in the same cycle as that vs_rise.
  - Clear the pixel, line and packing counters.
- State ACTIVE, packing:
  - Each valid pixel is written into lane pix_cnt[1:0] of the packing register.
  - Pixel 0 goes to bits [15:0]; pixel 3 goes to bits [63:48].
  - On the 4th pixel, wr_en goes high and wr_data is presented on the next clk edge (latency 1 cycle from the 4th valid). wr_en is high for 1 cycle per word.
- State ACTIVE, line accounting:
  - href_fall increments the line counter.
  - If the pixel count of the ending line is not H_PIXEL, set size_err.
  - A partial word left at line end is dropped, not written.
  - The pixel count is cleared at line end.
- State ACTIVE, frame end:
  - On vs_rise, pulse frame_done.
  - If the line count is not V_PIXEL, set size_err.
  - Then behave exactly as ARM receiving a vs_rise: pulse frame_start in the same cycle, clear counters and stay in ACTIVE (back-to-back frames).
- Overflow:
  - If a word completes while fifo_full = 1, wr_en stays low and ovf_err is set.
  - The state moves to DROP.
- State DROP:
  - All pixels are discarded.
  - On vs_rise, pulse frame_done only (no frame_start), then go to ARM.
  - Capture resumes at the following vs_rise, which ensures the frame buffer never receives a torn frame.
- Simultaneous events:
  - vs_rise and a valid pixel in the same cycle: the pixel is discarded.
  - href_fall and vs_rise in the same cycle: the line is counted before the frame check.
- Counter widths:
  - Pixel counter: $clog2(H_PIXEL+1) bits, saturating.
  - Line counter: $clog2(V_PIXEL+1) bits, saturating.
  - Saturation prevents wrap from masking size_err.
- Sticky flags clear only on reset.
- Asserting rst_n low mid-frame returns immediately to SKIP. Skipping restarts from 0.

Optional Feature:
- Macro: CMOS_WR_STAT_EN.
- Defined:
  - Adds outputs stat_lines[11:0] and stat_pixels[11:0].
  - On every frame-end vs_rise out of ACTIVE, these latch the line count of that frame and the pixel count of its last line.
  - Both reset to 0.
- Undefined:
  - The ports and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Skip, then normal capture:
  - Stimulus: SKIP_FRAMES = 2, H_PIXEL = 8, V_PIXEL = 2. Apply 4 vsync pulses with 2x8 pixels each, data = incrementing 16'h0001...
  - Required response: no wr_en during the first 2 frames. frame_start at the 3rd vs_rise. Then 4 words per frame; the first word is 64'h0004_0003_0002_0001.
- Write latency:
  - Stimulus: 4 consecutive valid pixels.
  - Required response: wr_en high exactly 1 clk after the 4th valid and for 1 cycle.
- Overflow:
  - Stimulus: hold fifo_full = 1 while the 2nd word of a frame completes.
  - Required response: ovf_err = 1. No further wr_en in that frame. frame_done at the next vs_rise with no frame_start. Capture resumes one frame later.
- Short line:
  - Stimulus: a line of 6 pixels when H_PIXEL = 8.
  - Required response: size_err = 1. Only 1 word written for that line. The next line packs from lane 0.
- Reset mid-frame:
  - Stimulus: pulse rst_n low during ACTIVE.
  - Required response: all outputs 0 immediately. SKIP_FRAMES frames are skipped again before the next frame_start.
- Statistics (CMOS_WR_STAT_EN defined):
  - Stimulus: a frame with 3 lines of 8 pixels.
  - Required response: stat_lines = 3 and stat_pixels = 8 after its closing vs_rise.
